mux_stream_rr: RTL and testbench

- Parametrised successor to the team's flat N:1 two-bit selector.
- Selects one of NUM_IN DATA_W-bit input channels onto a single registered output stream, using valid/ready handshakes on every channel.
- Two grant modes:
  - fixed-select: an external sel chooses the channel.
  - round-robin: fair arbitration across all valid channels.
- Sits between multiple producers and one consumer; output is a one-entry pipeline register.

---
 rtl/mux_stream_rr.sv | 124 ++++++++++++
 tb/tb_mux_stream_rr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream selector with fixed-select and round-robin grant modes.
// The output is a single registered beat; rr_ptr is the round-robin start index.
module mux_stream_rr #(
  parameter int unsigned NUM_IN = 32,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned SEL_W  = 5
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_chan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       err_sel
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_chan_q, out_chan_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              err_sel_q, err_sel_d;

  logic              load_c;
  logic              sel_ok_c;
  logic              fix_hit_c;
  logic [NUM_IN-1:0] rot_c;
  logic              rr_hit_c;
  int unsigned       rr_off_c;
  int unsigned       rr_idx_c;
  logic              grant_c;
  logic [SEL_W-1:0]  g_c;
  logic [DATA_W-1:0] g_data_c;
  logic              xfer_c;

  // Grant selection, handshake and next-state computation.
  always_comb begin
    load_c    = !out_valid_q || out_ready;
    sel_ok_c  = 1'b0;
    fix_hit_c = 1'b0;
    rr_hit_c  = 1'b0;
    rr_off_c  = 0;
    g_data_c  = '0;
    in_ready  = '0;

    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok_c  = 1'b1;
        fix_hit_c = in_valid[i];
      end
    end

    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the winner.
    rot_c = NUM_IN'({in_valid, in_valid} >> rr_ptr_q);
    for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
      if (rot_c[k]) begin
        rr_hit_c = 1'b1;
        rr_off_c = unsigned'(k);
      end
    end
    rr_idx_c = 32'(rr_ptr_q) + rr_off_c;
    if (rr_idx_c >= NUM_IN) rr_idx_c = rr_idx_c - NUM_IN;

    if (mode) begin
      grant_c = rr_hit_c;
      g_c     = SEL_W'(rr_idx_c);
    end else begin
      grant_c = fix_hit_c;
      g_c     = sel;
    end

    xfer_c = grant_c && load_c && RST_N;

    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (g_c == SEL_W'(i)) begin
        g_data_c    = in_data[i*DATA_W +: DATA_W];
        in_ready[i] = xfer_c;
      end
    end

    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    err_sel_d   = err_sel_q | (!mode && !sel_ok_c && load_c);

    if (xfer_c) begin
      out_data_d  = g_data_c;
      out_chan_d  = g_c;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = (32'(g_c) == NUM_IN - 1) ? '0 : SEL_W'(32'(g_c) + 1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: a 32-channel instance and a 31-channel
// instance (the latter exposes the out-of-range select error).
module tb_mux_stream_rr;

  logic        CLK;
  logic        RST_N;

  logic        mode, out_ready;
  logic [4:0]  sel;
  logic [63:0] in_data;
  logic [31:0] in_valid, in_ready;
  logic [1:0]  out_data;
  logic [4:0]  out_chan;
  logic        out_valid, err_sel;

  logic        b_mode, b_out_ready;
  logic [4:0]  b_sel;
  logic [61:0] b_in_data;
  logic [30:0] b_in_valid, b_in_ready;
  logic [1:0]  b_out_data;
  logic [4:0]  b_out_chan;
  logic        b_out_valid, b_err_sel;

  int n_assert;
  int n_fail;
  int exp_rr [6];

  mux_stream_rr #(.NUM_IN(32), .DATA_W(2), .SEL_W(5)) u_d32 (
    .CLK(CLK), .RST_N(RST_N), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .err_sel(err_sel)
  );

  mux_stream_rr #(.NUM_IN(31), .DATA_W(2), .SEL_W(5)) u_d31 (
    .CLK(CLK), .RST_N(RST_N), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err_sel(b_err_sel)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_rr   = '{3, 7, 30, 3, 7, 30};
    RST_N = 1'b0;
    mode = 1'b0; sel = '0; out_ready = 1'b1; in_valid = '1;
    b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1; b_in_valid = '1;
    for (int i = 0; i < 32; i++) in_data[i*2 +: 2] = 2'(i % 4);
    for (int i = 0; i < 31; i++) b_in_data[i*2 +: 2] = 2'(i % 4);

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_chan",  64'(out_chan),  64'd0);
    chk("rst_err_sel",   64'(err_sel),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    #11;
    RST_N = 1'b1;

    // Select sweep, one channel per cycle.
    for (int s = 0; s < 32; s++) begin
      sel = 5'(s);
      #1;
      chk("sweep_in_ready", 64'(in_ready), 64'(32'd1 << s));
      tick();
      chk("sweep_out_chan",  64'(out_chan),  64'(s));
      chk("sweep_out_data",  64'(out_data),  64'(s % 4));
      chk("sweep_out_valid", 64'(out_valid), 64'd1);
    end
    chk("sweep_err_sel", 64'(err_sel), 64'd0);

    // Backpressure: ch5 beat held while a new sel is presented.
    sel = 5'd5;
    tick();
    chk("bp_load_chan", 64'(out_chan), 64'd5);
    out_ready = 1'b0;
    sel = 5'd6;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data",  64'(out_data),  64'd1);
      chk("bp_out_chan",  64'(out_chan),  64'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'(32'd1 << 6));
    tick();
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_out_chan",  64'(out_chan),  64'd6);
    chk("b2b_out_data",  64'(out_data),  64'd2);

    // Round-robin across channels 3, 7 and 30.
    mode = 1'b1;
    in_valid = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 30);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_out_chan",  64'(out_chan),  64'(exp_rr[k]));
      chk("rr_out_valid", 64'(out_valid), 64'd1);
    end
    chk("rr_ch30_data", 64'(out_data), 64'd2);

    // Wrap: pointer sits at 31 after the ch30 grant.
    in_valid = 32'd1 | (32'd1 << 31);
    tick();
    chk("wrap_chan31", 64'(out_chan), 64'd31);
    chk("wrap_data31", 64'(out_data), 64'd3);
    tick();
    chk("wrap_chan0", 64'(out_chan), 64'd0);
    in_valid = 32'd3;
    tick();
    chk("wrap_ptr_is_1", 64'(out_chan), 64'd1);

    // Async reset during a stall.
    out_ready = 1'b0;
    #1;
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_out_chan",  64'(out_chan),  64'd0);
    chk("arst_err_sel",   64'(err_sel),   64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd0);
    #1;
    RST_N = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    tick();
    chk("arst_rr_first", 64'(out_chan), 64'd0);
    tick();
    chk("arst_rr_second", 64'(out_chan), 64'd1);

    // Out-of-range select on the 31-channel instance.
    chk("range_err_before", 64'(b_err_sel), 64'd0);
    b_sel = 5'd31;
    #1;
    chk("range_in_ready", 64'(b_in_ready), 64'd0);
    tick();
    chk("range_err_set",   64'(b_err_sel),   64'd1);
    chk("range_out_valid", 64'(b_out_valid), 64'd0);
    b_sel = 5'd0;
    #1;
    chk("range_resume_in_ready", 64'(b_in_ready), 64'd1);
    tick();
    chk("range_resume_valid", 64'(b_out_valid), 64'd1);
    chk("range_resume_chan",  64'(b_out_chan),  64'd0);
    chk("range_err_sticky",   64'(b_err_sel),   64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
